btn_sw_conditioner: RTL and testbench

Input front end for the Black-and-White card game top level. It turns the raw asynchronous pushbuttons and card-select slide switches into clean, synchronized signals for the game FSM. For buttons, that means debounced levels and single-cycle press pulses. For switches, it produces a debounced card vector with a one-hot/availability check and the encoded card index. It sits between the board pins and the game FSM, which consumes only `btn_pulse`, `sel_card`, `sel_valid` and `sel_index`.

---
 rtl/btn_sw_conditioner.sv | 113 +++++++++++
 tb/tb_btn_sw_conditioner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_sw_conditioner.sv
// Debounces raw buttons/switches into clean levels, single-cycle press pulses and a validated card pick.
// Latency: 2 sync + DEBOUNCE_CYCLES edges to levels, +1 to sel_valid/sel_index; no backpressure, pulses are fire-and-forget.
module btn_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    input  logic [8:0] sw_raw,
    input  logic [8:0] card_mask,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic [8:0] sel_card,
    output logic       sel_valid,
    output logic [3:0] sel_index
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [4:0]    btn_s1, btn_s2;
    logic [8:0]    sw_s1, sw_s2, sw_prev;
    logic [1:0]    fill;
    logic [4:0]    armed;
    logic [CW-1:0] btn_cnt [5];
    logic [CW-1:0] sw_cnt;

    logic [4:0]    btn_take, btn_cand, btn_win;
    logic          sw_restart, sw_take;
    logic [CW-1:0] sw_cnt_eff;
    logic          card_onehot, valid_nxt;
    logic [3:0]    card_pos;

    // fill marks when s2 holds a genuine pin sample rather than the reset zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_prev <= '0;
            fill    <= '0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            sw_s1   <= sw_raw;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
            if (fill != 2'd2) fill <= fill + 2'd1;
        end
    end

    always_comb begin
        btn_take = '0;
        for (int i = 0; i < 5; i++)
            btn_take[i] = (btn_s2[i] != btn_level[i]) && (btn_cnt[i] == CNT_LAST);
        btn_cand = btn_take & btn_s2 & armed;
        btn_win  = btn_cand & (~btn_cand + 5'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) btn_cnt[i] <= '0;
            btn_level <= '0;
            btn_pulse <= '0;
            armed     <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if ((btn_s2[i] == btn_level[i]) || btn_take[i])
                    btn_cnt[i] <= '0;
                else
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                if (btn_take[i]) btn_level[i] <= btn_s2[i];
            end
            btn_pulse <= btn_win;
            if (fill == 2'd2) armed <= armed | ~btn_s2;
        end
    end

    // a new switch pattern counts its first stable cycle from zero
    always_comb begin
        sw_restart = (sw_s2 != sw_prev);
        sw_cnt_eff = sw_restart ? '0 : sw_cnt;
        sw_take    = (sw_s2 != sel_card) && (sw_cnt_eff == CNT_LAST);
    end

    always_comb begin
        card_onehot = (sel_card != '0) && ((sel_card & (sel_card - 9'd1)) == '0);
        card_pos    = '0;
        for (int k = 0; k < 9; k++)
            if (sel_card[k]) card_pos = 4'(k);
        valid_nxt = card_onehot && ((sel_card & card_mask) != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_cnt    <= '0;
            sel_card  <= '0;
            sel_valid <= 1'b0;
            sel_index <= '0;
        end else begin
            if (sw_s2 == sel_card) begin
                sw_cnt <= '0;
            end else if (sw_take) begin
                sel_card <= sw_s2;
                sw_cnt   <= '0;
            end else begin
                sw_cnt <= sw_cnt_eff + 1'b1;
            end
            sel_valid <= valid_nxt;
            sel_index <= valid_nxt ? card_pos : 4'd0;
        end
    end
endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Randomized and directed bench for btn_sw_conditioner against a history-based reference model.
module tb_btn_sw_conditioner;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic [8:0] sw_raw;
    logic [8:0] card_mask;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [8:0] sel_card;
    logic       sel_valid;
    logic [3:0] sel_index;

    btn_sw_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .card_mask(card_mask), .btn_level(btn_level), .btn_pulse(btn_pulse),
        .sel_card(sel_card), .sel_valid(sel_valid), .sel_index(sel_index)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulse_cnt [5];

    // reference model state
    logic [4:0] m_b1, m_b2, m_lvl, m_pulse, m_armed;
    logic [8:0] m_s1, m_s2, m_sel;
    logic       m_valid;
    logic [3:0] m_idx;
    logic [4:0] bh [DC];
    logic [8:0] sh [DC];
    int         m_edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_b1 = '0; m_b2 = '0; m_lvl = '0; m_pulse = '0; m_armed = '0;
        m_s1 = '0; m_s2 = '0; m_sel = '0; m_valid = 1'b0; m_idx = '0;
        for (int j = 0; j < DC; j++) begin
            bh[j] = '0;
            sh[j] = '0;
        end
        m_edges = 0;
    endtask

    // One rising edge: levels accept after DC consecutive differing s2 samples,
    // s2 is the raw input delayed by two edges.
    task automatic model_edge();
        logic [4:0] s2b, new_lvl, rise;
        logic [8:0] s2s, new_sel;
        logic       all_diff, stable, found;
        int         ones;
        logic [3:0] idx;
        s2b = m_b2;
        s2s = m_s2;
        for (int j = DC - 1; j > 0; j--) begin
            bh[j] = bh[j-1];
            sh[j] = sh[j-1];
        end
        bh[0] = s2b;
        sh[0] = s2s;
        new_lvl = m_lvl;
        for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++)
                if (bh[j][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) new_lvl[i] = ~m_lvl[i];
        end
        rise = new_lvl & ~m_lvl & m_armed;
        m_pulse = '0;
        found = 1'b0;
        for (int i = 0; i < 5; i++)
            if (rise[i] && !found) begin
                m_pulse[i] = 1'b1;
                found = 1'b1;
            end
        if (m_edges >= 2) m_armed = m_armed | ~s2b;
        stable = 1'b1;
        for (int j = 0; j < DC; j++)
            if (sh[j] != sh[0]) stable = 1'b0;
        new_sel = (stable && sh[0] != m_sel) ? sh[0] : m_sel;
        ones = 0;
        idx = '0;
        for (int k = 0; k < 9; k++)
            if (m_sel[k]) begin
                ones++;
                idx = 4'(k);
            end
        m_valid = (ones == 1) && ((m_sel & card_mask) != '0);
        m_idx   = m_valid ? idx : 4'd0;
        m_sel   = new_sel;
        m_lvl   = new_lvl;
        m_b2 = m_b1; m_b1 = btn_raw;
        m_s2 = m_s1; m_s1 = sw_raw;
        m_edges++;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check("btn_level", btn_level, m_lvl);
        check("btn_pulse", btn_pulse, m_pulse);
        check("sel_card", sel_card, m_sel);
        check("sel_valid", sel_valid, m_valid);
        check("sel_index", sel_index, m_idx);
        for (int i = 0; i < 5; i++) pulse_cnt[i] += btn_pulse[i];
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_pulse_cnt();
        for (int i = 0; i < 5; i++) pulse_cnt[i] = 0;
    endtask

    // asserts reset between edges and checks the outputs clear without a clock
    task automatic async_reset(input int hold);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_level", btn_level, 5'd0);
        check("rst_pulse", btn_pulse, 5'd0);
        check("rst_card", sel_card, 9'd0);
        check("rst_valid", sel_valid, 1'b0);
        check("rst_index", sel_index, 4'd0);
        steps(hold);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btn_raw = 5'h1F;
        sw_raw = 9'h155;
        card_mask = 9'h1FF;
        clear_pulse_cnt();
        model_reset();
        steps(3);
        check("reset_level", btn_level, 5'd0);
        check("reset_card", sel_card, 9'd0);
        reset = 1'b0;
        btn_raw = '0;
        sw_raw = '0;
        steps(10);

        // clean press of top
        clear_pulse_cnt();
        btn_raw = 5'b00010;
        steps(5);
        check("press_lvl_early", btn_level[1], 1'b0);
        step();
        check("press_lvl", btn_level[1], 1'b1);
        check("press_pulse", btn_pulse, 5'b00010);
        step();
        check("press_pulse_drop", btn_pulse, 5'b00000);
        steps(5);
        btn_raw = 5'b00000;
        steps(5);
        check("release_lvl_early", btn_level[1], 1'b1);
        step();
        check("release_lvl", btn_level[1], 1'b0);
        steps(3);
        check("press_pulse_count", pulse_cnt[1], 1);

        // bounce on left
        clear_pulse_cnt();
        for (int k = 0; k < 12; k++) begin
            btn_raw = (k % 4 < 2) ? 5'b01000 : 5'b00000;
            step();
            check("bounce_quiet", btn_level[3], 1'b0);
        end
        btn_raw = 5'b01000;
        steps(5);
        check("bounce_lvl_early", btn_level[3], 1'b0);
        step();
        check("bounce_pulse", btn_pulse, 5'b01000);
        steps(4);
        check("bounce_pulse_count", pulse_cnt[3], 1);
        btn_raw = '0;
        steps(8);

        // simultaneous center + left
        clear_pulse_cnt();
        btn_raw = 5'b01001;
        steps(6);
        check("simul_pulse", btn_pulse, 5'b00001);
        check("simul_level", btn_level, 5'b01001);
        steps(10);
        check("simul_left_dropped", pulse_cnt[3], 0);
        check("simul_center_once", pulse_cnt[0], 1);
        btn_raw = '0;
        steps(8);

        // bottom held through reset
        btn_raw = 5'b00100;
        steps(2);
        async_reset(2);
        clear_pulse_cnt();
        steps(6);
        check("held_lvl", btn_level[2], 1'b1);
        steps(4);
        check("held_no_pulse", pulse_cnt[2], 0);
        btn_raw = '0;
        steps(8);
        btn_raw = 5'b00100;
        steps(10);
        check("repress_pulse_count", pulse_cnt[2], 1);
        btn_raw = '0;
        steps(8);

        // switch validation
        card_mask = 9'h1FF;
        sw_raw = 9'b000010000;
        steps(5);
        check("sw_card_early", sel_card, 9'd0);
        step();
        check("sw_card", sel_card, 9'b000010000);
        step();
        check("sw_valid", sel_valid, 1'b1);
        check("sw_index", sel_index, 4'd4);
        card_mask = 9'h1EF;
        step();
        check("mask_valid", sel_valid, 1'b0);
        check("mask_index", sel_index, 4'd0);
        card_mask = 9'h1FF;
        step();
        check("unmask_valid", sel_valid, 1'b1);
        sw_raw = 9'b000010001;
        steps(7);
        check("multi_card", sel_card, 9'b000010001);
        check("multi_valid", sel_valid, 1'b0);
        check("multi_index", sel_index, 4'd0);

        // randomized traffic with occasional mid-cycle reset
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                btn_raw = 5'($urandom);
                async_reset($urandom_range(1, 3));
            end else begin
                if (r < 50) btn_raw = btn_raw ^ (5'd1 << $urandom_range(0, 4));
                else if (r < 60) btn_raw = 5'($urandom);
                if (r % 5 == 0) sw_raw = 9'd1 << $urandom_range(0, 8);
                else if (r % 11 == 0) sw_raw = 9'($urandom);
                if (r % 7 == 0) card_mask = 9'($urandom);
            end
            steps($urandom_range(1, 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
